register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
- Parametrised successor of the 32x32 register file, used by the multi-cycle datapath's decode/writeback stages.
- Adds a configurable number of read ports, optional write-to-read bypass and a hardware clear sequencer after reset.
- Adds a per-register pending scoreboard so the control FSM can detect read-after-write hazards.

Parameters:
- DATA_WIDTH, 32, width of each register
- WORDS, 32, number of registers (power of two, >= 2)
- SELECT_SIZE, $clog2(WORDS), register select width
- READ_PORTS, 2, number of independent read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/reserves
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
- clk_i  in  1  clock; all state updates on posedge
- reset_i  in  1  synchronous, active-high reset
- reg_we_i  in  1  write enable, active low
- data_i  in  DATA_WIDTH  write data
- reg_dst_i  in  SELECT_SIZE  write destination
- reserve_i  in  1  active high; mark reserve_dst_i pending
- reserve_dst_i  in  SELECT_SIZE  register to reserve
- reg_src_i  in  READ_PORTS*SELECT_SIZE  packed read selects; port p = bits [p*SELECT_SIZE +: SELECT_SIZE]
- src_o  out  READ_PORTS*DATA_WIDTH  packed read data, same packing
- pending_o  out  READ_PORTS  pending bit of each port's selected register
- ready_o  out  1  high when clear sequence done and file is usable

Behaviour:
- Reset: one clock; synchronous, active-high reset_i.
  - While reset_i is high: FSM goes to CLEAR, clear index = 0, all pending bits = 0, ready_o = 0.
- FSM states CLEAR and RUN.
  - CLEAR: each cycle writes 0 to bank[index], then index++.
  - After index WORDS-1 is written, next state is RUN and ready_o = 1. Clearing takes exactly WORDS cycles after reset deasserts.
  - reset_i asserted mid-CLEAR or in RUN restarts CLEAR at index 0.
- Outputs during CLEAR:
  - src_o = 0 on all ports, pending_o = 0.
  - reg_we_i and reserve_i are ignored; no state change besides the sweep.
- Write in RUN: posedge, when reg_we_i == 0, bank[reg_dst_i] <= data_i. If ZERO_REG, writes to 0 are dropped.
- Read: combinational, per port.
  - If ZERO_REG and select == 0: output 0.
  - Else if BYPASS, reg_we_i == 0, state RUN and select == reg_dst_i (dst != 0 when ZERO_REG): output data_i.
  - Else output bank[select].
  - Multiple ports may select the same register.
- Scoreboard, RUN only:
  - A write (reg_we_i == 0) clears pending[reg_dst_i].
  - reserve_i sets pending[reserve_dst_i].
  - Same register written and reserved in one cycle: reserve wins, bit ends set.
  - Reserve of reg 0 is ignored when ZERO_REG.
  - pending_o[p] = pending[select_p]; it is 0 for reg 0 when ZERO_REG.
  - With BYPASS, a port whose register is being written this cycle (and not re-reserved) shows pending_o = 0.
- Write latency 1 cycle without bypass; 0 cycles with bypass.

Decomposition:
- Shared package regfile_pkg:
  - enum for FSM states (RF_CLEAR, RF_RUN).
  - Default width/depth constants.
  - Helper function to extract port p from a packed select/data vector.
- One natural sub-module: regfile_read_port, the per-port combinational mux (zero/bypass/bank, plus pending lookup), instantiated READ_PORTS times via generate.

Test Plan:
- Reset then hold idle -> ready_o low for exactly 32 cycles after reset_i falls, then high; all 32 registers read 0 on every port.
- RUN: write 0xDEADBEEF to reg 5 (reg_we_i = 0) -> with BYPASS=1, port0 selecting 5 shows 0xDEADBEEF in the same cycle; with BYPASS=0, it shows it the next cycle.
- Write 0x12345678 to reg 0 and reserve reg 0 -> reg 0 reads 0, pending_o = 0 on every port.
- Reserve reg 7 -> pending_o = 1 next cycle. Write reg 7 = 0xA5 -> pending clears. Reserve and write reg 7 in the same cycle -> pending stays 1 and data = new value.
- Write 0x55 to reg 3, then pulse reset_i mid-CLEAR at index 10 -> sweep restarts; ready_o rises 32 cycles after the second reset; reg 3 reads 0.
- READ_PORTS=4, all four ports select reg 9 holding 0x0F0F0F0F -> all four src_o slices equal 0x0F0F0F0F; writes attempted during CLEAR leave reg 9 = 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types, default sizes and packed-vector helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

  localparam int unsigned DefaultDataWidth = 32;
  localparam int unsigned DefaultWords     = 32;
  localparam int unsigned MaxPorts         = 4;
  localparam int unsigned MaxField         = 64;
  localparam int unsigned MaxPacked        = MaxPorts * MaxField;

  // Returns field p of width w from a packed vector zero-extended to MaxPacked bits.
  function automatic logic [MaxField-1:0] port_field(input logic [MaxPacked-1:0] vec,
                                                     input int unsigned p,
                                                     input int unsigned w);
    logic [MaxPacked-1:0] shifted;
    logic [MaxField-1:0]  mask;
    shifted = vec >> (p * w);
    mask    = (w >= MaxField) ? '1 : ((MaxField'(1) << w) - MaxField'(1));
    return shifted[MaxField-1:0] & mask;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: zero-register, write bypass or bank lookup, plus pending bit.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefaultDataWidth,
  parameter int unsigned WORDS       = DefaultWords,
  parameter int unsigned SELECT_SIZE = $clog2(WORDS),
  parameter bit          ZERO_REG    = 1'b1,
  parameter bit          BYPASS      = 1'b1
) (
  input  rf_state_e                          state,
  input  logic                               write_en,
  input  logic [SELECT_SIZE-1:0]             write_dst,
  input  logic [DATA_WIDTH-1:0]              write_data,
  input  logic                               reserve_en,
  input  logic [SELECT_SIZE-1:0]             reserve_dst,
  input  logic [WORDS-1:0][DATA_WIDTH-1:0]   bank,
  input  logic [WORDS-1:0]                   pending,
  input  logic [SELECT_SIZE-1:0]             sel,
  output logic [DATA_WIDTH-1:0]              data,
  output logic                               pend
);

  logic is_zero;
  logic hit;
  logic re_reserved;

  always_comb begin
    is_zero     = ZERO_REG && (sel == '0);
    hit         = BYPASS && write_en && (sel == write_dst);
    re_reserved = reserve_en && (reserve_dst == sel);
    data        = '0;
    pend        = 1'b0;
    if ((state == RF_RUN) && !is_zero) begin
      data = hit ? write_data : bank[sel];
      // A bypassed write resolves the hazard now unless the same register is re-reserved.
      pend = (hit && !re_reserved) ? 1'b0 : pending[sel];
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file with post-reset clear sweep, bypass and RAW scoreboard.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefaultDataWidth,
  parameter int unsigned WORDS       = DefaultWords,
  parameter int unsigned SELECT_SIZE = $clog2(WORDS),
  parameter int unsigned READ_PORTS  = 2,
  parameter bit          ZERO_REG    = 1'b1,
  parameter bit          BYPASS      = 1'b1
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              reg_we_i,
  input  logic [DATA_WIDTH-1:0]             data_i,
  input  logic [SELECT_SIZE-1:0]            reg_dst_i,
  input  logic                              reserve_i,
  input  logic [SELECT_SIZE-1:0]            reserve_dst_i,
  input  logic [READ_PORTS*SELECT_SIZE-1:0] reg_src_i,
  output logic [READ_PORTS*DATA_WIDTH-1:0]  src_o,
  output logic [READ_PORTS-1:0]             pending_o,
  output logic                              ready_o
);

  rf_state_e                        state_q, state_d;
  logic [SELECT_SIZE-1:0]           clr_idx_q, clr_idx_d;
  logic [WORDS-1:0][DATA_WIDTH-1:0] bank_q;
  logic [WORDS-1:0]                 pending_q, pending_d;
  logic                             write_en;
  logic                             reserve_en;
  logic [MaxPacked-1:0]             src_sel_pad;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == RF_CLEAR) begin
      clr_idx_d = clr_idx_q + SELECT_SIZE'(1);
      if (clr_idx_q == SELECT_SIZE'(WORDS - 1)) begin
        state_d   = RF_RUN;
        clr_idx_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= RF_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  assign ready_o    = (state_q == RF_RUN);
  assign write_en   = ready_o && !reg_we_i && !(ZERO_REG && (reg_dst_i == '0));
  assign reserve_en = ready_o && reserve_i && !(ZERO_REG && (reserve_dst_i == '0));

  // Bank has no reset of its own; the sweep clears it one word per cycle.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (state_q == RF_CLEAR) begin
        bank_q[clr_idx_q] <= '0;
      end else if (write_en) begin
        bank_q[reg_dst_i] <= data_i;
      end
    end
  end

  // Reserve is applied after the write clear so it wins on a same-register collision.
  always_comb begin
    pending_d = pending_q;
    if (write_en) begin
      pending_d[reg_dst_i] = 1'b0;
    end
    if (reserve_en) begin
      pending_d[reserve_dst_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign src_sel_pad = MaxPacked'(reg_src_i);

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    logic [SELECT_SIZE-1:0] sel;
    assign sel = SELECT_SIZE'(port_field(src_sel_pad, p, SELECT_SIZE));

    regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .WORDS      (WORDS),
      .SELECT_SIZE(SELECT_SIZE),
      .ZERO_REG   (ZERO_REG),
      .BYPASS     (BYPASS)
    ) u_read_port (
      .state      (state_q),
      .write_en   (write_en),
      .write_dst  (reg_dst_i),
      .write_data (data_i),
      .reserve_en (reserve_en),
      .reserve_dst(reserve_dst_i),
      .bank       (bank_q),
      .pending    (pending_q),
      .sel        (sel),
      .data       (src_o[p*DATA_WIDTH +: DATA_WIDTH]),
      .pend       (pending_o[p])
    );
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench: a 4-port bypassing file and a 2-port non-bypassing file driven in lockstep.
module tb_register_file_mp;

  logic         clk = 1'b0;
  logic         reset;
  logic         reg_we;
  logic         reserve;
  logic [31:0]  data;
  logic [4:0]   reg_dst;
  logic [4:0]   reserve_dst;
  logic [19:0]  reg_src;
  logic [127:0] src4;
  logic [3:0]   pend4;
  logic         ready4;
  logic [63:0]  src2;
  logic [1:0]   pend2;
  logic         ready2;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;

  always #5 clk = ~clk;

  register_file_mp #(
    .DATA_WIDTH(32),
    .WORDS     (32),
    .READ_PORTS(4),
    .ZERO_REG  (1'b1),
    .BYPASS    (1'b1)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .reg_we_i     (reg_we),
    .data_i       (data),
    .reg_dst_i    (reg_dst),
    .reserve_i    (reserve),
    .reserve_dst_i(reserve_dst),
    .reg_src_i    (reg_src),
    .src_o        (src4),
    .pending_o    (pend4),
    .ready_o      (ready4)
  );

  register_file_mp #(
    .DATA_WIDTH(32),
    .WORDS     (32),
    .READ_PORTS(2),
    .ZERO_REG  (1'b1),
    .BYPASS    (1'b0)
  ) dut_nb (
    .clk_i        (clk),
    .reset_i      (reset),
    .reg_we_i     (reg_we),
    .data_i       (data),
    .reg_dst_i    (reg_dst),
    .reserve_i    (reserve),
    .reserve_dst_i(reserve_dst),
    .reg_src_i    (reg_src[9:0]),
    .src_o        (src2),
    .pending_o    (pend2),
    .ready_o      (ready2)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sel_all(input logic [4:0] r);
    reg_src = {4{r}};
  endtask

  task automatic wait_ready();
    cyc = 0;
    while (!ready4 && cyc < 100) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    reset = 1'b1; reg_we = 1'b1; reserve = 1'b0; data = '0;
    reg_dst = '0; reserve_dst = '0; reg_src = '0;
    step();
    step();
    check("rst_ready", {126'd0, ready4, ready2}, 128'd0);
    check("rst_src", src4, 128'd0);
    check("rst_pend", {124'd0, pend4}, 128'd0);

    // Clear sweep, with a write+reserve of reg 9 attempted after its index was cleared.
    reset = 1'b0;
    cyc   = 0;
    while (!ready4 && cyc < 100) begin
      step();
      cyc++;
      if (cyc == 20) begin
        reg_we = 1'b0; reg_dst = 5'd9; data = 32'h0F0F_0F0F;
        reserve = 1'b1; reserve_dst = 5'd9; sel_all(5'd9);
        #1;
        check("clear_src", src4, 128'd0);
        check("clear_pend", {124'd0, pend4}, 128'd0);
      end else begin
        reg_we = 1'b1; reserve = 1'b0;
      end
    end
    check("ready_lat", 128'(cyc), 128'd32);
    check("ready_nb", {127'd0, ready2}, 128'd1);

    for (int r = 0; r < 32; r++) begin
      sel_all(5'(r));
      #1;
      check($sformatf("sweep_src_r%0d", r), src4, 128'd0);
      check($sformatf("sweep_pend_r%0d", r), {122'd0, pend4, pend2}, 128'd0);
    end

    // Bypass vs registered write latency.
    step();
    reg_we = 1'b0; reg_dst = 5'd5; data = 32'hDEAD_BEEF; sel_all(5'd5);
    #1;
    check("byp_same", {96'd0, src4[31:0]}, 128'hDEAD_BEEF);
    check("nobyp_same", {96'd0, src2[31:0]}, 128'd0);
    step();
    reg_we = 1'b1;
    #1;
    check("nobyp_next", {96'd0, src2[31:0]}, 128'hDEAD_BEEF);
    check("byp_next", src4, {4{32'hDEAD_BEEF}});

    // Register 0 ignores writes and reserves.
    step();
    reg_we = 1'b0; reg_dst = 5'd0; data = 32'h1234_5678;
    reserve = 1'b1; reserve_dst = 5'd0; sel_all(5'd0);
    #1;
    check("zero_src_same", src4, 128'd0);
    check("zero_pend_same", {122'd0, pend4, pend2}, 128'd0);
    step();
    reg_we = 1'b1; reserve = 1'b0;
    #1;
    check("zero_src4", src4, 128'd0);
    check("zero_src2", {64'd0, src2}, 128'd0);
    check("zero_pend", {122'd0, pend4, pend2}, 128'd0);

    // Scoreboard on reg 7.
    step();
    reserve = 1'b1; reserve_dst = 5'd7; sel_all(5'd7);
    #1;
    check("rsv_same", {122'd0, pend4, pend2}, 128'd0);
    step();
    reserve = 1'b0;
    #1;
    check("rsv_next", {122'd0, pend4, pend2}, 128'h3F);
    reg_we = 1'b0; reg_dst = 5'd7; data = 32'hA5;
    #1;
    check("wr_byp_pend", {122'd0, pend4, pend2}, 128'h03);
    check("wr_byp_data", {96'd0, src4[31:0]}, 128'hA5);
    step();
    reg_we = 1'b1;
    #1;
    check("wr_clr_pend", {122'd0, pend4, pend2}, 128'd0);
    check("wr_clr_data", {64'd0, src2}, {64'd0, {2{32'hA5}}});
    reg_we = 1'b0; data = 32'h77; reserve = 1'b1; reserve_dst = 5'd7;
    #1;
    check("rsvwr_byp_data", {96'd0, src4[31:0]}, 128'h77);
    step();
    reg_we = 1'b1; reserve = 1'b0;
    #1;
    check("rsvwr_pend", {122'd0, pend4, pend2}, 128'h3F);
    check("rsvwr_data4", src4, {4{32'h77}});
    check("rsvwr_data2", {64'd0, src2}, {64'd0, {2{32'h77}}});

    // All four ports on the same register.
    reg_we = 1'b0; reg_dst = 5'd9; data = 32'h0F0F_0F0F;
    step();
    reg_we = 1'b1; sel_all(5'd9);
    #1;
    check("quad_read", src4, {4{32'h0F0F_0F0F}});

    // Reset restarted mid-sweep.
    reg_we = 1'b0; reg_dst = 5'd3; data = 32'h55;
    step();
    reg_we = 1'b1; sel_all(5'd3);
    #1;
    check("r3_written", {96'd0, src2[31:0]}, 128'h55);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("mid_ready", {126'd0, ready4, ready2}, 128'd0);
    check("mid_src", src4, 128'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    wait_ready();
    check("restart_lat", 128'(cyc), 128'd32);
    sel_all(5'd3);
    #1;
    check("r3_cleared", src4, 128'd0);
    sel_all(5'd9);
    #1;
    check("r9_cleared", src4, 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
